div_ctrl_seq: RTL and testbench
===============================

// Module: div_ctrl_seq
// PURPOSE
//  Control-step sequencer upstream of the datapath: generates the T0..T6 strobes for fetch and
//  execution of two-result ALU ops (div, mul), replacing hand-driven testbench sequencing.
//  Handshakes with memory (mem_ready) and the multi-cycle ALU (alu_start/alu_done).
//  Moore FSM: all strobes decode from the registered state only.
// PARAMETERS
//  ALU_TIMEOUT  64  max cycles in T4 waiting for alu_done before FAULT
//  CNT_W        16  width of retired-instruction counter
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  reset      in   1      synchronous, active-high
//  run        in   1      1 = fetch next instruction after IDLE/T6
//  ir         in   32     IR contents: [31:27] opcode, [26:23] Ra, [22:19] Rb
//  mem_ready  in   1      memory read data valid this cycle
//  alu_done   in   1      ALU result valid in Z this cycle
//  PCout,MARin,IncPC,PCin,Read,MDRin,MDRout,IRin,Yin,Zin,Zlowout,Zhighout,LOin,HIin  out 1 each
//  Gra,Grb,Rout  out  1   register-select strobes into the register-file select logic
//  alu_start  out  1      one-cycle pulse launching the ALU op
//  alu_op     out  5      opcode to ALU (ir[31:27] in T4, else 5'b00000)
//  busy       out  1      state != IDLE/HALT/FAULT
//  halted     out  1      HALT state
//  fault      out  1      FAULT state (illegal opcode or ALU timeout)
//  retired    out  CNT_W  count of completed div/mul instructions
// BEHAVIOUR
//  Reset: state=IDLE, every strobe/alu_start/busy/halted/fault=0, retired=0, timeout ctr=0.
//   Reset mid-instruction aborts: IDLE on the next edge, no partial HI/LO write after that edge.
//  States and strobes (one cycle each unless noted):
//   IDLE: none. run=1 -> T0, else stay.
//   T0: PCout,MARin,IncPC,PCin -> T1.
//   T1: Read,MDRin; holds while mem_ready=0; mem_ready=1 -> T2.
//   T2: MDRout,IRin -> T3 (IR valid from T3 on).
//   T3: decode ir[31:27]: OP_DIV=5'b10000 or OP_MUL=5'b01111 -> Gra,Rout,Yin, next T4;
//       OP_HALT=5'b11011 -> HALT (no strobes in T3); any other -> FAULT.
//   T4: Grb,Rout,Zin asserted throughout; alu_start=1 only in first T4 cycle; alu_op=opcode.
//       alu_done=1 -> T5 (alu_done on the start cycle accepted). Timeout ctr increments each
//       T4 cycle; reaching ALU_TIMEOUT with alu_done=0 -> FAULT; alu_done wins if simultaneous.
//   T5: Zlowout,LOin (quotient/low product) -> T6.
//   T6: Zhighout,HIin (remainder/high product); retired+=1 (wraps at 2^CNT_W-1 -> 0);
//       run=1 -> T0, run=0 -> IDLE.
//   HALT, FAULT: sticky, no strobes; exit only via reset.
//  Invariants: at most one of PCout/MDRout/Rout/Zlowout/Zhighout high in any cycle (bus
//   one-hot); Gra and Grb never both high; run is sampled only in IDLE and T6.
//  Latency: IDLE->T6 = 7 cycles with mem_ready and alu_done both asserted on first cycle.
// STRUCTURE
//  Package div_ctrl_pkg: state enum (IDLE,T0..T6,HALT,FAULT, 4-bit), OP_DIV/OP_MUL/OP_HALT.
//  Sub-module ctrl_timeout_ctr: clear/enable/terminal-count counter, width $clog2(ALU_TIMEOUT+1).
//  Top: state register, next-state logic, strobe decode, retired counter.
// TESTING
//  ir=32'h80918000 (div R1,R2), run=1, mem_ready/alu_done immediate -> T0..T6 in 7 cycles,
//   strobe set per state exact, alu_start 1 cycle, retired=1, busy low after T6 with run=0.
//  mem_ready delayed 3 cycles in T1 -> Read,MDRin held 4 cycles, IRin not asserted early.
//  alu_done delayed 10 cycles, ir mul (5'b01111) -> Zin held 11 cycles, alu_start single pulse,
//   LOin then HIin on consecutive cycles.
//  alu_done never asserted -> FAULT after exactly 64 T4 cycles, fault=1, all strobes 0.
//  ir opcode 5'b00101 -> FAULT from T3, no Yin; opcode 5'b11011 -> halted=1, retired unchanged.
//  reset asserted in T5 -> next edge IDLE, HIin never asserted; back-to-back run=1 x3 -> retired=3.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared states, opcodes and strobe decode for the div/mul control sequencer
package div_ctrl_pkg;
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT, FAULT} state_t;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_HALT = 5'b11011;
  typedef struct packed {
    logic pc_out, mar_in, inc_pc, pc_in;
    logic read, mdr_in, mdr_out, ir_in;
    logic y_in, z_in, zlow_out, zhigh_out;
    logic lo_in, hi_in, gra, grb, r_out;
  } strobes_t;
  function automatic logic is_alu_op(input logic [4:0] op);
    return op == OP_DIV || op == OP_MUL;
  endfunction
  function automatic strobes_t decode(input state_t s, input logic [4:0] op);
    strobes_t d;
    d = '0;
    {d.pc_out, d.mar_in, d.inc_pc, d.pc_in} = {4{s == T0}};
    {d.read, d.mdr_in} = {2{s == T1}};
    {d.mdr_out, d.ir_in} = {2{s == T2}};
    {d.gra, d.y_in} = {2{s == T3 && is_alu_op(op)}};
    {d.grb, d.z_in} = {2{s == T4}};
    d.r_out = d.gra || d.grb;
    {d.zlow_out, d.lo_in} = {2{s == T5}};
    {d.zhigh_out, d.hi_in} = {2{s == T6}};
    return d;
  endfunction
endpackage

// File: rtl/div_ctrl_seq_if.sv
// div_ctrl_seq_if: sequencer handshake inputs and control-step strobes
interface div_ctrl_seq_if #(parameter int CNT_W = 16);
  logic run, mem_ready, alu_done;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin;
  logic Zlowout, Zhighout, LOin, HIin, Gra, Grb, Rout;
  logic alu_start;
  logic [4:0] alu_op;
  logic busy, halted, fault;
  logic [CNT_W-1:0] retired;
  modport master (
    input run, ir, mem_ready, alu_done,
    output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin,
    output Zlowout, Zhighout, LOin, HIin, Gra, Grb, Rout,
    output alu_start, alu_op, busy, halted, fault, retired
  );
  modport slave (
    output run, ir, mem_ready, alu_done,
    input PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin,
    input Zlowout, Zhighout, LOin, HIin, Gra, Grb, Rout,
    input alu_start, alu_op, busy, halted, fault, retired
  );
endinterface

// File: rtl/div_ctrl_seq_timeout.sv
// ctrl_timeout_ctr: clearable up-counter flagging the first and the last allowed cycle
module ctrl_timeout_ctr #(
  parameter int MAX = 64,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic first,
  output logic tc
);
  logic [W-1:0] cnt;
  // counts consecutive enabled cycles since the last clear
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : en ? cnt + W'(1) : cnt;
  assign first = cnt == '0;
  assign tc = en && cnt == W'(MAX - 1);
endmodule

// File: rtl/div_ctrl_seq.sv
// div_ctrl_seq: Moore control-step sequencer for fetch and two-result div/mul execution
module div_ctrl_seq #(
  parameter int ALU_TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  div_ctrl_seq_if.master bus
);
  import div_ctrl_pkg::*;
  state_t state, nxt;
  strobes_t str;
  logic [4:0] op;
  logic first, tc;
  logic [CNT_W-1:0] retired;
  assign op = bus.ir[31:27];
  ctrl_timeout_ctr #(.MAX(ALU_TIMEOUT)) u_timeout (
    .clk(clk),
    .rst(reset),
    .clr(state != T4),
    .en(state == T4),
    .first(first),
    .tc(tc)
  );
  // next state; run only matters in IDLE and T6, alu_done beats the timeout
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = bus.run ? T0 : IDLE;
      T0: nxt = T1;
      T1: nxt = bus.mem_ready ? T2 : T1;
      T2: nxt = T3;
      T3: nxt = is_alu_op(op) ? T4 : op == OP_HALT ? HALT : FAULT;
      T4: nxt = bus.alu_done ? T5 : tc ? FAULT : T4;
      T5: nxt = T6;
      T6: nxt = bus.run ? T0 : IDLE;
      default: nxt = state;
    endcase
  end
  // state register and retired-instruction count (wraps naturally)
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      retired <= '0;
    end else begin
      state <= nxt;
      retired <= retired + CNT_W'(state == T6);
    end
  assign str = decode(state, op);
  assign {bus.PCout, bus.MARin, bus.IncPC, bus.PCin, bus.Read, bus.MDRin, bus.MDRout, bus.IRin,
          bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout, bus.LOin, bus.HIin, bus.Gra, bus.Grb,
          bus.Rout} = str;
  assign bus.alu_start = state == T4 && first;
  assign bus.alu_op = state == T4 ? op : '0;
  assign bus.busy = !(state inside {IDLE, HALT, FAULT});
  assign bus.halted = state == HALT;
  assign bus.fault = state == FAULT;
  assign bus.retired = retired;
endmodule

// File: tb/tb_div_ctrl_seq.sv
// tb_div_ctrl_seq: table-driven and directed checks of the div/mul control sequencer
module tb_div_ctrl_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int zin, starts, n;
  logic [16:0] str;
  localparam logic [16:0] S_NONE = 17'b0000_0000_0000_0000_0;
  localparam logic [16:0] S_T0   = 17'b1111_0000_0000_0000_0;
  localparam logic [16:0] S_T1   = 17'b0000_1100_0000_0000_0;
  localparam logic [16:0] S_T2   = 17'b0000_0011_0000_0000_0;
  localparam logic [16:0] S_T3   = 17'b0000_0000_1000_0010_1;
  localparam logic [16:0] S_T4   = 17'b0000_0000_0100_0001_1;
  localparam logic [16:0] S_T5   = 17'b0000_0000_0010_1000_0;
  localparam logic [16:0] S_T6   = 17'b0000_0000_0001_0100_0;
  localparam logic [31:0] IR_DIV  = 32'h80918000;
  localparam logic [31:0] IR_MUL  = 32'h78000000;
  localparam logic [31:0] IR_BAD  = 32'h28000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  typedef struct {
    string name;
    logic run, mr, ad;
    logic [16:0] str;
    logic start;
    logic [4:0] op;
    logic busy;
    logic [15:0] ret;
  } vec_t;
  vec_t tbl [9];
  div_ctrl_seq_if #(.CNT_W(16)) bus();
  div_ctrl_seq #(.ALU_TIMEOUT(64), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign str = {bus.PCout, bus.MARin, bus.IncPC, bus.PCin, bus.Read, bus.MDRin, bus.MDRout,
                bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout, bus.LOin, bus.HIin,
                bus.Gra, bus.Grb, bus.Rout};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    bus.alu_done = 1'b0;
    steps(2);
    reset = 1'b0;
  endtask
  // bus one-hot and Gra/Grb exclusivity hold every cycle
  always @(negedge clk)
    if (!reset) begin
      checks++;
      if ($countones({bus.PCout, bus.MDRout, bus.Rout, bus.Zlowout, bus.Zhighout}) > 1 ||
          (bus.Gra && bus.Grb)) begin
        errors++;
        $display("FAIL bus_invariant: strobes %b", str);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{"idle_to_t0", 1'b1, 1'b1, 1'b1, S_T0, 1'b0, 5'd0, 1'b1, 16'd0};
    tbl[1] = '{"t1", 1'b1, 1'b1, 1'b1, S_T1, 1'b0, 5'd0, 1'b1, 16'd0};
    tbl[2] = '{"t2", 1'b1, 1'b1, 1'b1, S_T2, 1'b0, 5'd0, 1'b1, 16'd0};
    tbl[3] = '{"t3", 1'b1, 1'b1, 1'b1, S_T3, 1'b0, 5'd0, 1'b1, 16'd0};
    tbl[4] = '{"t4", 1'b1, 1'b1, 1'b1, S_T4, 1'b1, 5'b10000, 1'b1, 16'd0};
    tbl[5] = '{"t5", 1'b1, 1'b1, 1'b1, S_T5, 1'b0, 5'd0, 1'b1, 16'd0};
    tbl[6] = '{"t6", 1'b1, 1'b1, 1'b1, S_T6, 1'b0, 5'd0, 1'b1, 16'd0};
    tbl[7] = '{"t6_to_idle", 1'b0, 1'b1, 1'b1, S_NONE, 1'b0, 5'd0, 1'b0, 16'd1};
    tbl[8] = '{"idle_hold", 1'b0, 1'b1, 1'b1, S_NONE, 1'b0, 5'd0, 1'b0, 16'd1};
    bus.ir = IR_DIV;
    do_reset();
    chk("rst_strobes", str, S_NONE);
    chk("rst_busy", bus.busy, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_retired", bus.retired, 0);
    chk("rst_alu_start", bus.alu_start, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    for (int i = 0; i < 9; i++) begin
      bus.run = tbl[i].run;
      bus.mem_ready = tbl[i].mr;
      bus.alu_done = tbl[i].ad;
      step();
      chk({tbl[i].name, "_strobes"}, str, tbl[i].str);
      chk({tbl[i].name, "_alu_start"}, bus.alu_start, tbl[i].start);
      chk({tbl[i].name, "_alu_op"}, bus.alu_op, tbl[i].op);
      chk({tbl[i].name, "_busy"}, bus.busy, tbl[i].busy);
      chk({tbl[i].name, "_retired"}, bus.retired, tbl[i].ret);
    end
    do_reset();
    bus.ir = IR_DIV;
    bus.run = 1'b1;
    bus.alu_done = 1'b1;
    steps(2);
    chk("memwait_t1_1", str, S_T1);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk($sformatf("memwait_t1_%0d", i), str, S_T1);
    end
    bus.mem_ready = 1'b1;
    step();
    chk("memwait_t2", str, S_T2);
    bus.run = 1'b0;
    steps(4);
    chk("memwait_t6", str, S_T6);
    step();
    chk("memwait_idle_busy", bus.busy, 0);
    chk("memwait_retired", bus.retired, 1);
    do_reset();
    bus.ir = IR_MUL;
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    steps(5);
    chk("mul_t4_strobes", str, S_T4);
    chk("mul_alu_op", bus.alu_op, 5'b01111);
    zin = 0;
    starts = 0;
    for (int c = 1; c <= 11; c++) begin
      zin += int'(bus.Zin);
      starts += int'(bus.alu_start);
      if (c == 11) bus.alu_done = 1'b1;
      step();
    end
    chk("mul_zin_cycles", zin, 11);
    chk("mul_alu_start_pulses", starts, 1);
    chk("mul_t5_strobes", str, S_T5);
    bus.alu_done = 1'b0;
    bus.run = 1'b0;
    step();
    chk("mul_t6_strobes", str, S_T6);
    step();
    chk("mul_retired", bus.retired, 1);
    chk("mul_idle_busy", bus.busy, 0);
    do_reset();
    bus.ir = IR_DIV;
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    steps(5);
    n = 0;
    while (!bus.fault && n < 200) begin
      n += int'(bus.Zin);
      step();
    end
    chk("timeout_t4_cycles", n, 64);
    chk("timeout_fault", bus.fault, 1);
    chk("timeout_strobes", str, S_NONE);
    chk("timeout_busy", bus.busy, 0);
    chk("timeout_alu_op", bus.alu_op, 0);
    bus.alu_done = 1'b1;
    steps(3);
    chk("fault_sticky", bus.fault, 1);
    chk("fault_sticky_strobes", str, S_NONE);
    do_reset();
    bus.ir = IR_BAD;
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    bus.alu_done = 1'b1;
    steps(4);
    chk("illegal_t3_strobes", str, S_NONE);
    chk("illegal_t3_yin", bus.Yin, 0);
    step();
    chk("illegal_fault", bus.fault, 1);
    chk("illegal_busy", bus.busy, 0);
    chk("illegal_retired", bus.retired, 0);
    do_reset();
    bus.ir = IR_DIV;
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    bus.alu_done = 1'b1;
    steps(21);
    chk("b2b_third_t6", str, S_T6);
    chk("b2b_retired_2", bus.retired, 2);
    step();
    chk("b2b_retired_3", bus.retired, 3);
    chk("b2b_fourth_t0", str, S_T0);
    bus.ir = IR_HALT;
    steps(3);
    chk("halt_t3_strobes", str, S_NONE);
    step();
    chk("halt_halted", bus.halted, 1);
    chk("halt_busy", bus.busy, 0);
    chk("halt_fault", bus.fault, 0);
    chk("halt_retired", bus.retired, 3);
    steps(2);
    chk("halt_sticky", bus.halted, 1);
    chk("halt_sticky_strobes", str, S_NONE);
    do_reset();
    bus.ir = IR_DIV;
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    bus.alu_done = 1'b1;
    steps(6);
    chk("abort_t5", str, S_T5);
    reset = 1'b1;
    step();
    chk("abort_strobes", str, S_NONE);
    chk("abort_busy", bus.busy, 0);
    reset = 1'b0;
    bus.run = 1'b0;
    step();
    chk("abort_idle_strobes", str, S_NONE);
    chk("abort_hiin", bus.HIin, 0);
    chk("abort_retired", bus.retired, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
